// File: rtl/ysyx_25040101_ifu_if.sv
// ---------------------------------------------------------------------------
// ysyx_25040101_ifu_if
// Instruction-memory bus between the fetch unit and instruction memory.
// One request channel (valid/ready/addr) and one response channel
// (valid pulse, data, access-fault flag). The response channel has no
// ready signal: the fetch unit keeps at most one request outstanding, so it
// can always take the response.
//   master : fetch unit side (drives the request, receives the response)
//   slave  : memory side (accepts the request, returns the response)
// ---------------------------------------------------------------------------
interface ysyx_25040101_ifu_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_err
    );
endinterface

// File: rtl/ysyx_25040101_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_25040101_ifu
// Instruction fetch unit. Issues one word-aligned fetch at a time, waits for
// the single-cycle response pulse, and holds the fetched instruction for the
// decode stage until it is consumed or a redirect discards it.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem              : instruction-memory bus (master side)
//   redirect_valid/pc : next-PC override from execute (low two bits ignored)
//   inst_valid/ready  : handshake to decode
//   inst_o, pc_o      : held instruction and its PC
//   opcode_o, func3_o, func7_o : fields of the held instruction
//   fetch_fault_o     : held instruction came from a faulting access
// ---------------------------------------------------------------------------
module ysyx_25040101_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ysyx_25040101_ifu_if.master        imem,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [31:0]                inst_o,
    output logic [31:0]                pc_o,
    output logic [6:0]                 opcode_o,
    output logic [2:0]                 func3_o,
    output logic                       func7_o,
    output logic                       fetch_fault_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e      state_r;
    state_e      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic        drop_r;
    logic        drop_next_s;
    logic        load_s;
    logic [31:0] redirect_pc_s;
    logic        req_valid_r;
    logic        inst_valid_r;
    logic [31:0] inst_r;
    logic [31:0] pc_o_r;
    logic        fault_r;

    // Redirect targets are forced word-aligned before they reach the PC.
    assign redirect_pc_s = redirect_pc & 32'hFFFF_FFFC;

    // Next-state and datapath-control decode for the fetch FSM.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        drop_next_s  = drop_r;
        load_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                state_next_s = S_REQ;
                if (redirect_valid) begin
                    pc_next_s = redirect_pc_s;
                end else begin
                    pc_next_s = pc_r;
                end
            end
            S_REQ: begin
                // A redirect that coincides with acceptance cannot cancel the
                // in-flight request, so its response is marked for dropping.
                if (imem.req_ready) begin
                    state_next_s = S_WAIT;
                    drop_next_s  = redirect_valid;
                end else begin
                    state_next_s = S_REQ;
                end
                if (redirect_valid) begin
                    pc_next_s = redirect_pc_s;
                end else begin
                    pc_next_s = pc_r;
                end
            end
            S_WAIT: begin
                if (imem.resp_valid) begin
                    drop_next_s = 1'b0;
                    if (drop_r || redirect_valid) begin
                        state_next_s = S_REQ;
                    end else begin
                        state_next_s = S_HOLD;
                        load_s       = 1'b1;
                    end
                end else begin
                    state_next_s = S_WAIT;
                    if (redirect_valid) begin
                        drop_next_s = 1'b1;
                    end else begin
                        drop_next_s = drop_r;
                    end
                end
                if (redirect_valid) begin
                    pc_next_s = redirect_pc_s;
                end else begin
                    pc_next_s = pc_r;
                end
            end
            S_HOLD: begin
                // Redirect wins over consumption: the held instruction is
                // on the wrong path.
                if (redirect_valid) begin
                    pc_next_s    = redirect_pc_s;
                    state_next_s = S_REQ;
                end else if (inst_ready) begin
                    pc_next_s    = pc_r + 32'd4;
                    state_next_s = S_REQ;
                end else begin
                    state_next_s = S_HOLD;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // FSM state, fetch PC, drop flag and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            pc_r         <= RESET_PC;
            drop_r       <= 1'b0;
            req_valid_r  <= 1'b0;
            inst_valid_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            pc_r         <= pc_next_s;
            drop_r       <= drop_next_s;
            req_valid_r  <= (state_next_s == S_REQ);
            inst_valid_r <= (state_next_s == S_HOLD);
        end
    end

    // Captures the accepted response; a faulting access presents a zero word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_r  <= 32'h0000_0000;
            pc_o_r  <= 32'h0000_0000;
            fault_r <= 1'b0;
        end else if (load_s) begin
            inst_r  <= imem.resp_err ? 32'h0000_0000 : imem.resp_data;
            pc_o_r  <= pc_r;
            fault_r <= imem.resp_err;
        end else begin
            inst_r  <= inst_r;
            pc_o_r  <= pc_o_r;
            fault_r <= fault_r;
        end
    end

    assign imem.req_valid = req_valid_r;
    assign imem.req_addr  = pc_r;
    assign inst_valid     = inst_valid_r;
    assign inst_o         = inst_r;
    assign pc_o           = pc_o_r;
    assign fetch_fault_o  = fault_r;
    assign opcode_o       = inst_r[6:0];
    assign func3_o        = inst_r[14:12];
    assign func7_o        = inst_r[30];

endmodule

// File: tb/tb_ysyx_25040101_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25040101_ifu
// Directed bench for the fetch unit: a small memory responder with settable
// latency and fault address, a transaction-level model of the fetch
// behaviour, a per-cycle compare against that model, and literal checks of
// the key scenarios.
// ---------------------------------------------------------------------------
module tb_ysyx_25040101_ifu;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [6:0]  opcode_o;
    logic [2:0]  func3_o;
    logic        func7_o;
    logic        fetch_fault_o;

    ysyx_25040101_ifu_if imem ();

    ysyx_25040101_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_o         (inst_o),
        .pc_o           (pc_o),
        .opcode_o       (opcode_o),
        .func3_o        (func3_o),
        .func7_o        (func7_o),
        .fetch_fault_o  (fetch_fault_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    int          resp_lat   = 0;
    logic [31:0] fault_addr = 32'h1234_5670;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0010_0093 ^ {a[15:0], 16'h0000};
    endfunction

    initial begin
        imem.req_ready  = 1'b0;
        imem.resp_valid = 1'b0;
        imem.resp_data  = 32'h0;
        imem.resp_err   = 1'b0;
    end

    // Responder keeps its pending response across DUT reset on purpose.
    always @(posedge clk) begin : responder
        logic        fire;
        logic [31:0] a;
        static logic        pend = 1'b0;
        static int          cnt = 0;
        static logic [31:0] p_addr = 32'h0;
        fire = imem.req_valid && imem.req_ready;
        a    = imem.req_addr;
        #1;
        imem.resp_valid = 1'b0;
        imem.resp_err   = 1'b0;
        if (pend) begin
            if (cnt == 0) begin
                imem.resp_valid = 1'b1;
                imem.resp_data  = mem_word(p_addr);
                imem.resp_err   = (p_addr == fault_addr);
                pend = 1'b0;
            end else begin
                cnt = cnt - 1;
            end
        end
        if (fire) begin
            if (resp_lat == 0) begin
                imem.resp_valid = 1'b1;
                imem.resp_data  = mem_word(a);
                imem.resp_err   = (a == fault_addr);
            end else begin
                pend   = 1'b1;
                cnt    = resp_lat - 1;
                p_addr = a;
            end
        end
    end

    // ---------------- behavioural model ----------------
    // m_idle: first cycle out of reset; m_out: a request is outstanding;
    // m_stale: the outstanding response belongs to an abandoned path;
    // m_held: an instruction is offered to decode.
    logic        m_idle  = 1'b1;
    logic        m_out   = 1'b0;
    logic        m_stale = 1'b0;
    logic        m_held  = 1'b0;
    logic [31:0] m_pc    = RESET_PC;
    logic [31:0] h_inst  = 32'h0;
    logic [31:0] h_pc    = 32'h0;
    logic        h_fault = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] tgt;
        tgt = {redirect_pc[31:2], 2'b00};
        if (!rst_n) begin
            m_idle = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_held = 1'b0;
            m_pc = RESET_PC; h_inst = 32'h0; h_pc = 32'h0; h_fault = 1'b0;
        end else if (m_idle) begin
            m_idle = 1'b0;
            if (redirect_valid) m_pc = tgt;
        end else if (m_held) begin
            if (redirect_valid) begin
                m_held = 1'b0; m_pc = tgt;
            end else if (inst_ready) begin
                m_held = 1'b0; m_pc = m_pc + 32'd4;
            end
        end else if (m_out) begin
            if (imem.resp_valid) begin
                m_out = 1'b0;
                if (m_stale || redirect_valid) begin
                    m_stale = 1'b0;
                end else begin
                    m_held  = 1'b1;
                    h_inst  = imem.resp_err ? 32'h0 : imem.resp_data;
                    h_pc    = m_pc;
                    h_fault = imem.resp_err;
                end
            end else if (redirect_valid) begin
                m_stale = 1'b1;
            end
            if (redirect_valid) m_pc = tgt;
        end else begin
            if (imem.req_ready) begin
                m_out = 1'b1;
                if (redirect_valid) m_stale = 1'b1;
            end
            if (redirect_valid) m_pc = tgt;
        end
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin : compare
        check("req_valid", {31'd0, imem.req_valid}, {31'd0, !m_idle && !m_out && !m_held});
        check("req_addr", imem.req_addr, m_pc);
        check("inst_valid", {31'd0, inst_valid}, {31'd0, m_held});
        check("inst_o", inst_o, h_inst);
        check("pc_o", pc_o, h_pc);
        check("fault", {31'd0, fetch_fault_o}, {31'd0, h_fault});
        check("opcode", {25'd0, opcode_o}, {25'd0, h_inst[6:0]});
        check("func3", {29'd0, func3_o}, {29'd0, h_inst[14:12]});
        check("func7", {31'd0, func7_o}, {31'd0, h_inst[30]});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        tick();
        tick();
        check("rst_addr", imem.req_addr, 32'h8000_0000);
        check("rst_req_valid", {31'd0, imem.req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst_o", inst_o, 32'h0);
        rst_n = 1'b1;
        imem.req_ready = 1'b1;

        // First fetch: accept, one-cycle response, held two cycles after acceptance.
        tick();
        check("first_req_valid", {31'd0, imem.req_valid}, 32'd1);
        check("first_addr", imem.req_addr, 32'h8000_0000);
        tick();
        check("wait_no_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check("first_inst_valid", {31'd0, inst_valid}, 32'd1);
        check("first_inst", inst_o, 32'h0010_0093);
        check("first_opcode", {25'd0, opcode_o}, 32'h0000_0013);
        check("first_func3", {29'd0, func3_o}, 32'd0);
        check("first_func7", {31'd0, func7_o}, 32'd0);
        check("first_pc", pc_o, 32'h8000_0000);

        // Back-pressure from decode for five cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_inst", inst_o, 32'h0010_0093);
            check("stall_pc", pc_o, 32'h8000_0000);
            check("stall_valid", {31'd0, inst_valid}, 32'd1);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("seq_addr", imem.req_addr, 32'h8000_0004);
        check("seq_req_valid", {31'd0, imem.req_valid}, 32'd1);
        tick();
        tick();
        check("second_inst", inst_o, 32'h0014_0093);

        // Redirect while waiting on a slower response: response dropped.
        resp_lat = 2;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("third_addr", imem.req_addr, 32'h8000_0008);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        check("wredir_no_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check("wredir_no_valid2", {31'd0, inst_valid}, 32'd0);
        tick();
        check("wredir_addr", imem.req_addr, 32'h8000_0100);
        check("wredir_req_valid", {31'd0, imem.req_valid}, 32'd1);
        check("wredir_inst_valid", {31'd0, inst_valid}, 32'd0);
        resp_lat = 0;
        tick();
        tick();
        check("redir_pc", pc_o, 32'h8000_0100);
        check("redir_inst", inst_o, 32'h0110_0093);

        // Redirect and inst_ready together in HOLD: redirect wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        inst_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        check("hredir_addr", imem.req_addr, 32'h8000_0200);
        check("hredir_inst_valid", {31'd0, inst_valid}, 32'd0);

        // Faulting access.
        fault_addr = 32'h8000_0200;
        tick();
        tick();
        check("fault_valid", {31'd0, inst_valid}, 32'd1);
        check("fault_inst", inst_o, 32'h0);
        check("fault_flag", {31'd0, fetch_fault_o}, 32'd1);
        check("fault_pc", pc_o, 32'h8000_0200);
        fault_addr = 32'h1234_5670;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("after_fault_addr", imem.req_addr, 32'h8000_0204);

        // Redirect coinciding with request acceptance.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0303;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("hsredir_addr", imem.req_addr, 32'h8000_0300);
        check("hsredir_inst_valid", {31'd0, inst_valid}, 32'd0);

        // Redirect in REQ without handshake, then PC wrap.
        imem.req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        check("top_addr", imem.req_addr, 32'hFFFF_FFFC);
        imem.req_ready = 1'b1;
        tick();
        tick();
        check("top_pc", pc_o, 32'hFFFF_FFFC);
        resp_lat   = 3;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("wrap_addr", imem.req_addr, 32'h0000_0000);

        // Reset during WAIT with the response arriving after release.
        tick();
        imem.req_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_addr", imem.req_addr, 32'h8000_0000);
        check("mid_rst_req_valid", {31'd0, imem.req_valid}, 32'd0);
        check("mid_rst_pc", pc_o, 32'h0);
        check("mid_rst_fault", {31'd0, fetch_fault_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("late_req_valid", {31'd0, imem.req_valid}, 32'd1);
        check("late_addr", imem.req_addr, 32'h8000_0000);
        tick();
        check("late_ignored", {31'd0, inst_valid}, 32'd0);
        check("late_inst_o", inst_o, 32'h0);
        resp_lat = 0;
        imem.req_ready = 1'b1;
        tick();
        tick();
        check("post_rst_inst", inst_o, 32'h0010_0093);
        check("post_rst_pc", pc_o, 32'h8000_0000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
